// File: rtl/branch_compare_pkg.sv
// Shared types and the condition evaluator for the branch compare unit.
package branch_compare_pkg;

   typedef enum logic [2:0] {
      CMP_EQ  = 3'd0,
      CMP_NE  = 3'd1,
      CMP_LT  = 3'd2,
      CMP_LTU = 3'd3,
      CMP_GE  = 3'd4,
      CMP_GEU = 3'd5,
      CMP_LEZ = 3'd6,
      CMP_GTZ = 3'd7
   } cmp_mode_e;

   // Width-independent relations between the operands. The top derives these
   // at its own WIDTH, so the mode decode below stays free of parameters.
   typedef struct packed {
      logic eq;      // A == B
      logic lt_s;    // signed A < B
      logic lt_u;    // unsigned A < B (borrow of WIDTH+1-bit subtract)
      logic a_neg;   // A < 0 (sign bit)
      logic a_zero;  // A == 0
   } cmp_flags_t;

   function automatic logic cmp_eval(input cmp_mode_e mode, input cmp_flags_t f);
      logic res;
      res = 1'b0;
      unique case (mode)
         CMP_EQ:  res = f.eq;
         CMP_NE:  res = ~f.eq;
         CMP_LT:  res = f.lt_s;
         CMP_LTU: res = f.lt_u;
         CMP_GE:  res = ~f.lt_s;
         CMP_GEU: res = ~f.lt_u;
         CMP_LEZ: res = f.a_neg | f.a_zero;
         CMP_GTZ: res = ~f.a_neg & ~f.a_zero;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/branch_compare_unit_stage.sv
// One elastic pipeline register holding {valid, result, tag}.
// result/tag only change when a valid entry is loaded, so they hold across bubbles.
module compare_pipe_stage
   import branch_compare_pkg::*;
#(
   parameter int unsigned TAG_WIDTH = 5
) (
   input  logic                 clock__i,
   input  logic                 reset_n__i,
   input  logic                 flush__i,
   input  logic                 load__i,
   input  logic                 valid__i,
   input  logic                 result__i,
   input  logic [TAG_WIDTH-1:0] tag__i,
   output logic                 valid__o,
   output logic                 result__o,
   output logic [TAG_WIDTH-1:0] tag__o
);

   logic                 valid_q,  valid_d;
   logic                 result_q, result_d;
   logic [TAG_WIDTH-1:0] tag_q,    tag_d;

   // Next-state: flush empties the slot, load replaces it, otherwise hold.
   always_comb begin
      valid_d  = valid_q;
      result_d = result_q;
      tag_d    = tag_q;
      if (flush__i) begin
         valid_d = 1'b0;
      end else if (load__i) begin
         valid_d = valid__i;
         if (valid__i) begin
            result_d = result__i;
            tag_d    = tag__i;
         end
      end
   end

   // Stage register with synchronous active-low reset.
   always_ff @(posedge clock__i) begin
      if (!reset_n__i) begin
         valid_q  <= 1'b0;
         result_q <= 1'b0;
         tag_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         tag_q    <= tag_d;
      end
   end

   assign valid__o  = valid_q;
   assign result__o = result_q;
   assign tag__o    = tag_q;

endmodule

// File: rtl/branch_compare_unit.sv
// Pipelined multi-mode branch condition evaluator with elastic valid/ready
// pipeline, flush, and saturating delivered/taken counters.
module branch_compare_unit
   import branch_compare_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned LATENCY   = 1,
   parameter int unsigned TAG_WIDTH = 5,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clock__i,
   input  logic                 reset_n__i,
   input  logic                 flush__i,
   input  logic                 valid__i,
   output logic                 ready__o,
   input  logic [2:0]           mode__i,
   input  logic [WIDTH-1:0]     dataA__i,
   input  logic [WIDTH-1:0]     dataB__i,
   input  logic [TAG_WIDTH-1:0] tag__i,
   output logic                 valid__o,
   input  logic                 ready__i,
   output logic                 result__o,
   output logic [TAG_WIDTH-1:0] tag__o,
   input  logic                 clear__i,
   output logic [CNT_WIDTH-1:0] cmp_count__o,
   output logic [CNT_WIDTH-1:0] tkn_count__o
);

   // ---------------- compare at accept ----------------
   logic [WIDTH:0] diff_w;
   cmp_flags_t     flags;
   logic           eval_res;
   logic           accept;

   assign diff_w = {1'b0, dataA__i} - {1'b0, dataB__i};

   // Derive operand relations; when signs differ the negative operand is the smaller one.
   always_comb begin
      flags.eq     = (dataA__i == dataB__i);
      flags.lt_u   = diff_w[WIDTH];
      flags.lt_s   = (dataA__i[WIDTH-1] != dataB__i[WIDTH-1]) ? dataA__i[WIDTH-1]
                                                              : diff_w[WIDTH];
      flags.a_neg  = dataA__i[WIDTH-1];
      flags.a_zero = (dataA__i == '0);
      eval_res     = cmp_eval(cmp_mode_e'(mode__i), flags);
   end

   // ---------------- elastic stage chain ----------------
   logic [LATENCY-1:0]   stg_valid;
   logic [LATENCY-1:0]   stg_result;
   logic [TAG_WIDTH-1:0] stg_tag [LATENCY];
   // load_chain[k]: stage k may load this cycle; load_chain[LATENCY] is the consumer.
   logic [LATENCY:0]     load_chain;

   // Ready chain, resolved from the output end back toward the input.
   always_comb begin
      int unsigned k;
      load_chain          = '0;
      load_chain[LATENCY] = ready__i;
      for (int unsigned i = 0; i < LATENCY; i++) begin
         k             = LATENCY - 1 - i;
         load_chain[k] = ~stg_valid[k] | load_chain[k+1];
      end
   end

   assign ready__o = reset_n__i & ~flush__i & load_chain[0];
   assign accept   = valid__i & ready__o;

   for (genvar g = 0; g < LATENCY; g++) begin : g_stage
      logic                 in_valid;
      logic                 in_result;
      logic [TAG_WIDTH-1:0] in_tag;

      if (g == 0) begin : g_head
         assign in_valid  = accept;
         assign in_result = eval_res;
         assign in_tag    = tag__i;
      end else begin : g_body
         assign in_valid  = stg_valid[g-1];
         assign in_result = stg_result[g-1];
         assign in_tag    = stg_tag[g-1];
      end

      compare_pipe_stage #(
         .TAG_WIDTH (TAG_WIDTH)
      ) u_stage (
         .clock__i   (clock__i),
         .reset_n__i (reset_n__i),
         .flush__i   (flush__i),
         .load__i    (load_chain[g]),
         .valid__i   (in_valid),
         .result__i  (in_result),
         .tag__i     (in_tag),
         .valid__o   (stg_valid[g]),
         .result__o  (stg_result[g]),
         .tag__o     (stg_tag[g])
      );
   end

   assign valid__o  = stg_valid[LATENCY-1];
   assign result__o = stg_result[LATENCY-1];
   assign tag__o    = stg_tag[LATENCY-1];

   // ---------------- statistics ----------------
   logic                 deliver;
   logic [CNT_WIDTH-1:0] cmp_cnt_q, cmp_cnt_d;
   logic [CNT_WIDTH-1:0] tkn_cnt_q, tkn_cnt_d;

   // A handshake still counts when flush is asserted in the same cycle.
   assign deliver = valid__o & ready__i;

   // Saturating counter next-state; clear wins over increment.
   always_comb begin
      cmp_cnt_d = cmp_cnt_q;
      tkn_cnt_d = tkn_cnt_q;
      if (clear__i) begin
         cmp_cnt_d = '0;
         tkn_cnt_d = '0;
      end else if (deliver) begin
         if (cmp_cnt_q != '1)
            cmp_cnt_d = cmp_cnt_q + 1'b1;
         if (result__o && (tkn_cnt_q != '1))
            tkn_cnt_d = tkn_cnt_q + 1'b1;
      end
   end

   // Counter registers with synchronous active-low reset.
   always_ff @(posedge clock__i) begin
      if (!reset_n__i) begin
         cmp_cnt_q <= '0;
         tkn_cnt_q <= '0;
      end else begin
         cmp_cnt_q <= cmp_cnt_d;
         tkn_cnt_q <= tkn_cnt_d;
      end
   end

   assign cmp_count__o = cmp_cnt_q;
   assign tkn_count__o = tkn_cnt_q;

endmodule

// File: tb/tb_branch_compare_unit.sv
// Directed bench for branch_compare_unit: a LATENCY=1 / CNT_WIDTH=4 instance
// and a LATENCY=3 instance share one clock and are exercised in turn.
module tb_branch_compare_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---- instance 1: LATENCY=1, CNT_WIDTH=4 ----
   logic        d1_rst_n, d1_flush, d1_valid_i, d1_ready_o, d1_ready_i;
   logic        d1_valid_o, d1_result, d1_clear;
   logic [2:0]  d1_mode;
   logic [31:0] d1_a, d1_b;
   logic [4:0]  d1_tag_i, d1_tag_o;
   logic [3:0]  d1_cmp, d1_tkn;

   // ---- instance 3: LATENCY=3, CNT_WIDTH=16 ----
   logic        d3_rst_n, d3_flush, d3_valid_i, d3_ready_o, d3_ready_i;
   logic        d3_valid_o, d3_result, d3_clear;
   logic [2:0]  d3_mode;
   logic [31:0] d3_a, d3_b;
   logic [4:0]  d3_tag_i, d3_tag_o;
   logic [15:0] d3_cmp, d3_tkn;

   branch_compare_unit #(
      .WIDTH(32), .LATENCY(1), .TAG_WIDTH(5), .CNT_WIDTH(4)
   ) dut1 (
      .clock__i(clk), .reset_n__i(d1_rst_n), .flush__i(d1_flush),
      .valid__i(d1_valid_i), .ready__o(d1_ready_o), .mode__i(d1_mode),
      .dataA__i(d1_a), .dataB__i(d1_b), .tag__i(d1_tag_i),
      .valid__o(d1_valid_o), .ready__i(d1_ready_i), .result__o(d1_result),
      .tag__o(d1_tag_o), .clear__i(d1_clear),
      .cmp_count__o(d1_cmp), .tkn_count__o(d1_tkn)
   );

   branch_compare_unit #(
      .WIDTH(32), .LATENCY(3), .TAG_WIDTH(5), .CNT_WIDTH(16)
   ) dut3 (
      .clock__i(clk), .reset_n__i(d3_rst_n), .flush__i(d3_flush),
      .valid__i(d3_valid_i), .ready__o(d3_ready_o), .mode__i(d3_mode),
      .dataA__i(d3_a), .dataB__i(d3_b), .tag__i(d3_tag_i),
      .valid__o(d3_valid_o), .ready__i(d3_ready_i), .result__o(d3_result),
      .tag__o(d3_tag_o), .clear__i(d3_clear),
      .cmp_count__o(d3_cmp), .tkn_count__o(d3_tkn)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed vector table for instance 1 (expected results hand-computed).
   logic [2:0]  v_mode [16];
   logic [31:0] v_a    [16];
   logic [31:0] v_b    [16];
   logic        v_exp  [16];

   task automatic set_vec(input int i, input logic [2:0] m, input logic [31:0] a,
                          input logic [31:0] b, input logic e);
      v_mode[i] = m; v_a[i] = a; v_b[i] = b; v_exp[i] = e;
   endtask

   // Back-to-back stream through instance 1, one result per cycle.
   task automatic stream1(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         d1_valid_i = 1'b1;
         d1_mode    = v_mode[i];
         d1_a       = v_a[i];
         d1_b       = v_b[i];
         d1_tag_i   = 5'(i + 1);
         tick();
         check($sformatf("s1_valid[%0d]", i), d1_valid_o, 1'b1);
         check($sformatf("s1_result[%0d]", i), d1_result, v_exp[i]);
         check($sformatf("s1_tag[%0d]", i), d1_tag_o, 32'(i + 1));
      end
      d1_valid_i = 1'b0;
      tick();
      check("s1_idle_valid", d1_valid_o, 1'b0);
   endtask

   initial begin
      int acc;
      int idx;
      logic rdy;
      logic [4:0] st_tag [5];
      logic [2:0] st_mode [5];
      logic [31:0] st_a [5];
      logic [31:0] st_b [5];

      set_vec(0,  3'd0, 32'd5,          32'd5,          1'b1); // EQ
      set_vec(1,  3'd1, 32'd5,          32'd5,          1'b0); // NE
      set_vec(2,  3'd2, 32'hFFFF_FFFF,  32'd0,          1'b1); // LT  -1<0
      set_vec(3,  3'd3, 32'hFFFF_FFFF,  32'd0,          1'b0); // LTU
      set_vec(4,  3'd6, 32'd0,          32'h0000_1234,  1'b1); // LEZ 0
      set_vec(5,  3'd6, 32'h8000_0000,  32'd0,          1'b1); // LEZ min
      set_vec(6,  3'd7, 32'd1,          32'hFFFF_FFFF,  1'b1); // GTZ 1
      set_vec(7,  3'd7, 32'd0,          32'h0000_0055,  1'b0); // GTZ 0
      set_vec(8,  3'd4, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b1); // GE max>=-1
      set_vec(9,  3'd5, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0); // GEU
      set_vec(10, 3'd2, 32'h7FFF_FFFF,  32'h8000_0000,  1'b0); // LT
      set_vec(11, 3'd3, 32'h7FFF_FFFF,  32'h8000_0000,  1'b1); // LTU
      set_vec(12, 3'd4, 32'h8000_0000,  32'h8000_0000,  1'b1); // GE equal
      set_vec(13, 3'd6, 32'd1,          32'd0,          1'b0); // LEZ 1
      set_vec(14, 3'd7, 32'h8000_0000,  32'd0,          1'b0); // GTZ min
      set_vec(15, 3'd1, 32'd0,          32'h8000_0000,  1'b1); // NE

      d1_rst_n = 1'b0; d1_flush = 1'b0; d1_valid_i = 1'b0; d1_ready_i = 1'b1;
      d1_clear = 1'b0; d1_mode = '0; d1_a = '0; d1_b = '0; d1_tag_i = '0;
      d3_rst_n = 1'b0; d3_flush = 1'b0; d3_valid_i = 1'b0; d3_ready_i = 1'b1;
      d3_clear = 1'b0; d3_mode = '0; d3_a = '0; d3_b = '0; d3_tag_i = '0;

      tick();
      tick();
      check("rst1_valid",  d1_valid_o, 1'b0);
      check("rst1_result", d1_result,  1'b0);
      check("rst1_tag",    d1_tag_o,   '0);
      check("rst1_cmp",    d1_cmp,     '0);
      check("rst1_tkn",    d1_tkn,     '0);
      check("rst1_ready",  d1_ready_o, 1'b0);
      check("rst3_valid",  d3_valid_o, 1'b0);
      check("rst3_ready",  d3_ready_o, 1'b0);

      d1_rst_n = 1'b1;
      d3_rst_n = 1'b1;
      #1;
      check("rel1_ready", d1_ready_o, 1'b1);
      check("rel3_ready", d3_ready_o, 1'b1);

      // ---- instance 1: basic back-to-back, then boundary/zero modes ----
      stream1(0, 3);
      check("s1a_cmp", d1_cmp, 32'd4);
      check("s1a_tkn", d1_tkn, 32'd2);
      stream1(4, 15);
      check("s1b_cmp_sat", d1_cmp, 32'd15);
      check("s1b_tkn",     d1_tkn, 32'd9);

      // 20 taken results: both counters pinned at 15
      d1_valid_i = 1'b1; d1_mode = 3'd0; d1_a = 32'd0; d1_b = 32'd0; d1_tag_i = 5'd30;
      repeat (20) tick();
      d1_valid_i = 1'b0;
      tick();
      check("sat_cmp", d1_cmp, 32'd15);
      check("sat_tkn", d1_tkn, 32'd15);

      // clear coinciding with a handshake
      d1_valid_i = 1'b1; d1_mode = 3'd1; d1_a = 32'd1; d1_b = 32'd2; d1_tag_i = 5'd7;
      tick();
      check("clr_pre_valid",  d1_valid_o, 1'b1);
      check("clr_pre_result", d1_result,  1'b1);
      d1_valid_i = 1'b0;
      d1_clear   = 1'b1;
      tick();
      d1_clear = 1'b0;
      check("clr_cmp", d1_cmp, '0);
      check("clr_tkn", d1_tkn, '0);
      d1_valid_i = 1'b1; d1_mode = 3'd1; d1_a = 32'd1; d1_b = 32'd1; d1_tag_i = 5'd9;
      tick();
      d1_valid_i = 1'b0;
      tick();
      check("post_clr_cmp", d1_cmp, 32'd1);
      check("post_clr_tkn", d1_tkn, 32'd0);

      // ---- instance 3: flush with two in flight and a new offer ----
      d3_valid_i = 1'b1; d3_mode = 3'd0; d3_a = 32'd1; d3_b = 32'd1; d3_tag_i = 5'd1;
      tick();
      d3_tag_i = 5'd2;
      tick();
      check("fl_pre_valid", d3_valid_o, 1'b0);
      d3_flush = 1'b1; d3_tag_i = 5'd3;
      #1;
      check("fl_ready", d3_ready_o, 1'b0);
      tick();
      check("fl_valid", d3_valid_o, 1'b0);
      d3_flush = 1'b0;
      d3_valid_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("fl_drain_valid[%0d]", c), d3_valid_o, 1'b0);
      end
      check("fl_cmp", d3_cmp, '0);

      // ---- instance 3: stall with 5 requests offered ----
      st_tag[0] = 5'd11; st_mode[0] = 3'd3; st_a[0] = 32'hFFFF_FFFF; st_b[0] = 32'd0;         // 0
      st_tag[1] = 5'd12; st_mode[1] = 3'd4; st_a[1] = 32'hFFFF_FFFB; st_b[1] = 32'hFFFF_FFFB; // 1
      st_tag[2] = 5'd13; st_mode[2] = 3'd1; st_a[2] = 32'd1;         st_b[2] = 32'd2;         // 1
      st_tag[3] = 5'd14; st_mode[3] = 3'd0; st_a[3] = 32'd3;         st_b[3] = 32'd3;
      st_tag[4] = 5'd15; st_mode[4] = 3'd0; st_a[4] = 32'd4;         st_b[4] = 32'd4;
      d3_ready_i = 1'b0;
      acc = 0;
      idx = 0;
      for (int c = 0; c < 4; c++) begin
         d3_valid_i = 1'b1;
         d3_mode    = st_mode[idx];
         d3_a       = st_a[idx];
         d3_b       = st_b[idx];
         d3_tag_i   = st_tag[idx];
         #1;
         rdy = d3_ready_o;
         tick();
         if (rdy) begin
            acc++;
            idx++;
         end
         if (c >= 2) begin
            check($sformatf("st_valid[%0d]", c), d3_valid_o, 1'b1);
            check($sformatf("st_tag[%0d]", c),   d3_tag_o,   32'd11);
         end
      end
      check("st_accepted", acc, 32'd3);
      #1;
      check("st_ready_full", d3_ready_o, 1'b0);
      check("st_head_result", d3_result, 1'b0);
      d3_valid_i = 1'b0;
      d3_ready_i = 1'b1;
      tick();
      check("st_out1_valid",  d3_valid_o, 1'b1);
      check("st_out1_tag",    d3_tag_o,   32'd12);
      check("st_out1_result", d3_result,  1'b1);
      tick();
      check("st_out2_valid",  d3_valid_o, 1'b1);
      check("st_out2_tag",    d3_tag_o,   32'd13);
      check("st_out2_result", d3_result,  1'b1);
      tick();
      check("st_drained", d3_valid_o, 1'b0);
      check("st_cmp",     d3_cmp,     32'd3);
      check("st_tkn",     d3_tkn,     32'd2);

      // ---- instance 3: reset mid-stream while stalled ----
      d3_ready_i = 1'b0;
      d3_valid_i = 1'b1; d3_mode = 3'd0; d3_a = 32'd2; d3_b = 32'd2; d3_tag_i = 5'd20;
      tick();
      d3_tag_i = 5'd21;
      tick();
      d3_valid_i = 1'b0;
      d3_rst_n   = 1'b0;
      tick();
      check("mr_valid",  d3_valid_o, 1'b0);
      check("mr_result", d3_result,  1'b0);
      check("mr_tag",    d3_tag_o,   '0);
      check("mr_cmp",    d3_cmp,     '0);
      check("mr_tkn",    d3_tkn,     '0);
      check("mr_ready",  d3_ready_o, 1'b0);
      d3_rst_n   = 1'b1;
      d3_ready_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         check($sformatf("mr_after_valid[%0d]", c), d3_valid_o, 1'b0);
      end
      check("mr_after_cmp", d3_cmp, '0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
